// File: rtl/cordic_sched_pkg.sv
// Shared defaults and tag type for the CORDIC time-multiplexing scheduler.
package cordic_sched_pkg;

  localparam int unsigned NumChDefault    = 4;
  localparam int unsigned LatencyDefault  = 13;
  localparam int unsigned BitwidthDefault = 16;
  localparam int unsigned ZwidthDefault   = 16;
  localparam int unsigned ChwDefault      = $clog2(NumChDefault);

  // Tag channel field is sized for the largest supported channel count (8)
  localparam int unsigned TagChW = 3;

  typedef struct packed {
    logic              valid;
    logic [TagChW-1:0] chan;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last winner.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CHW    = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant,
  output logic [CHW-1:0]    grant_idx
);

  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] cand;
  logic           found;

  // First requesting channel after the pointer, wrapping around
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = CHW'((32'(ptr_q) + k) % NUM_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
    ptr_d = accept ? grant_idx : ptr_q;
  end

  // Pointer starts at the last channel so channel 0 wins first
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= CHW'(NUM_CH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one pipelined CORDIC among NUM_CH requesters and routes results back by tag.
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = NumChDefault,
  parameter int unsigned BITWIDTH = BitwidthDefault,
  parameter int unsigned ZWIDTH   = ZwidthDefault,
  parameter int unsigned LATENCY  = LatencyDefault,
  parameter int unsigned CHW      = $clog2(NUM_CH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH*BITWIDTH-1:0] req_x,
  input  logic [NUM_CH*BITWIDTH-1:0] req_y,
  input  logic [NUM_CH*ZWIDTH-1:0]   req_z,
  output logic                       cordic_enable,
  output logic [BITWIDTH-1:0]        cordic_xi,
  output logic [BITWIDTH-1:0]        cordic_yi,
  output logic [ZWIDTH-1:0]          cordic_zi,
  input  logic [BITWIDTH-1:0]        cordic_xo,
  input  logic [BITWIDTH-1:0]        cordic_yo,
  input  logic [ZWIDTH-1:0]          cordic_zo,
  output logic [NUM_CH-1:0]          res_valid,
  output logic [BITWIDTH-1:0]        res_x,
  output logic [BITWIDTH-1:0]        res_y,
  output logic [ZWIDTH-1:0]          res_z,
  output logic [CHW-1:0]             res_chan,
  output logic                       busy
);

  // Tag pipe is one deeper than the CORDIC so the result register lines up with the tail
  localparam int unsigned Depth = LATENCY + 1;

  logic                en;
  logic [NUM_CH-1:0]   grant;
  logic [CHW-1:0]      grant_idx;
  logic                hs;
  logic [BITWIDTH-1:0] sel_x, sel_y;
  logic [ZWIDTH-1:0]   sel_z;

  logic [BITWIDTH-1:0] xi_q, xi_d, yi_q, yi_d;
  logic [ZWIDTH-1:0]   zi_q, zi_d;
  tag_t                tag_q [Depth];
  tag_t                tag_d [Depth];
  tag_t                tail;

  logic [NUM_CH-1:0]   res_valid_q, res_valid_d;
  logic [BITWIDTH-1:0] res_x_q, res_x_d, res_y_q, res_y_d;
  logic [ZWIDTH-1:0]   res_z_q, res_z_d;
  logic [CHW-1:0]      res_chan_q, res_chan_d;

  assign en            = ~reset & ~stall;
  assign cordic_enable = en;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CHW    (CHW)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid & {NUM_CH{en}}),
    .accept    (hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is only ever given to a valid channel, so any grant is a handshake
  assign req_ready = grant;
  assign hs        = |grant;
  assign tail      = tag_q[Depth-1];

  // Operand mux for the granted channel
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_z = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_x = req_x[i*BITWIDTH +: BITWIDTH];
        sel_y = req_y[i*BITWIDTH +: BITWIDTH];
        sel_z = req_z[i*ZWIDTH +: ZWIDTH];
      end
    end
  end

  // Next-state for operand regs, tag pipe and result regs
  always_comb begin
    xi_d = stall ? xi_q : (hs ? sel_x : '0);
    yi_d = stall ? yi_q : (hs ? sel_y : '0);
    zi_d = stall ? zi_q : (hs ? sel_z : '0);

    tag_d[0].valid = stall ? tag_q[0].valid : hs;
    tag_d[0].chan  = stall ? tag_q[0].chan  : TagChW'(grant_idx);
    for (int unsigned i = 1; i < Depth; i++) begin
      tag_d[i] = stall ? tag_q[i] : tag_q[i-1];
    end

    res_valid_d = '0;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_z_d     = res_z_q;
    res_chan_d  = res_chan_q;
    if (!stall && tail.valid) begin
      res_x_d    = cordic_xo;
      res_y_d    = cordic_yo;
      res_z_d    = cordic_zo;
      res_chan_d = tail.chan[CHW-1:0];
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        res_valid_d[i] = (tail.chan == TagChW'(i));
      end
    end
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      xi_q        <= '0;
      yi_q        <= '0;
      zi_q        <= '0;
      res_valid_q <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_z_q     <= '0;
      res_chan_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      zi_q        <= zi_d;
      res_valid_q <= res_valid_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_z_q     <= res_z_d;
      res_chan_q  <= res_chan_d;
      for (int unsigned i = 0; i < Depth; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Any valid tag anywhere in the pipe means work is in flight
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

  assign cordic_xi = xi_q;
  assign cordic_yi = yi_q;
  assign cordic_zi = zi_q;
  assign res_valid = res_valid_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_z     = res_z_q;
  assign res_chan  = res_chan_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Randomized bench for cordic_scheduler with a stub CORDIC and a queue-based reference model.
module tb_cordic_scheduler;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 13;

  logic             clock = 1'b0;
  logic             reset, stall;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_x, req_y, req_z;
  logic             cordic_enable;
  logic [W-1:0]     cordic_xi, cordic_yi, cordic_zi;
  logic [W-1:0]     cordic_xo, cordic_yo, cordic_zo;
  logic [N-1:0]     res_valid;
  logic [W-1:0]     res_x, res_y, res_z;
  logic [1:0]       res_chan;
  logic             busy;

  always #5 clock = ~clock;

  cordic_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_z         (req_z),
    .cordic_enable (cordic_enable),
    .cordic_xi     (cordic_xi),
    .cordic_yi     (cordic_yi),
    .cordic_zi     (cordic_zi),
    .cordic_xo     (cordic_xo),
    .cordic_yo     (cordic_yo),
    .cordic_zo     (cordic_zo),
    .res_valid     (res_valid),
    .res_x         (res_x),
    .res_y         (res_y),
    .res_z         (res_z),
    .res_chan      (res_chan),
    .busy          (busy)
  );

  // Arbitrary but distinct transform standing in for the rotation
  function automatic logic [3*W-1:0] cordic_fn(input logic [3*W-1:0] a);
    logic [W-1:0] x, y, z;
    x = a[3*W-1:2*W];
    y = a[2*W-1:W];
    z = a[W-1:0];
    return {x + y, y - x, z ^ 16'hA5C3};
  endfunction

  // Stub CORDIC: LAT enabled register stages
  logic [3*W-1:0] cpipe [LAT];
  always @(posedge clock) begin
    if (cordic_enable) begin
      for (int k = LAT - 1; k > 0; k--) cpipe[k] <= cpipe[k-1];
      cpipe[0] <= {cordic_xi, cordic_yi, cordic_zi};
    end
  end
  assign {cordic_xo, cordic_yo, cordic_zo} = cordic_fn(cpipe[LAT-1]);

  typedef struct {
    int           chan;
    logic [W-1:0] x, y, z;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           ptr;
  int           en_cnt;
  int           n_checks, n_errors;
  bit           rand_data;
  logic [W-1:0] dx [N];
  logic [W-1:0] dy [N];
  logic [W-1:0] dz [N];
  logic [W-1:0] exp_xi, exp_yi, exp_zi, exp_rx, exp_ry, exp_rz;
  int           exp_rc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check grant, advance model, check registered outputs
  task automatic cycle(input logic [N-1:0] v, input logic st, input logic rst);
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_rv;
    logic [2*W-1:0] unused_hi;
    logic [3*W-1:0] r;
    int gch;
    exp_t e;
    reset = rst;
    stall = st;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      if (rand_data) begin
        dx[i] = W'($urandom);
        dy[i] = W'($urandom);
        dz[i] = W'($urandom);
      end
      req_x[i*W +: W] = dx[i];
      req_y[i*W +: W] = dy[i];
      req_z[i*W +: W] = dz[i];
    end
    #1;
    exp_g = '0;
    gch = -1;
    if (!rst && !st) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (gch < 0 && v[c]) gch = c;
      end
    end
    if (gch >= 0) exp_g[gch] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_g));
    check_eq("cordic_enable", 32'(cordic_enable), 32'(!rst && !st));

    @(posedge clock);
    #1;
    exp_rv = '0;
    if (rst) begin
      q.delete();
      ptr = N - 1;
      exp_xi = '0; exp_yi = '0; exp_zi = '0;
      exp_rx = '0; exp_ry = '0; exp_rz = '0; exp_rc = 0;
    end else if (!st) begin
      en_cnt++;
      if (gch >= 0) begin
        ptr = gch;
        exp_xi = dx[gch]; exp_yi = dy[gch]; exp_zi = dz[gch];
        r = cordic_fn({dx[gch], dy[gch], dz[gch]});
        e.chan = gch;
        e.x = r[3*W-1:2*W];
        e.y = r[2*W-1:W];
        e.z = r[W-1:0];
        e.due = en_cnt + LAT + 1;
        q.push_back(e);
      end else begin
        exp_xi = '0; exp_yi = '0; exp_zi = '0;
      end
      if (q.size() > 0 && q[0].due == en_cnt) begin
        e = q.pop_front();
        exp_rv[e.chan] = 1'b1;
        exp_rx = e.x; exp_ry = e.y; exp_rz = e.z; exp_rc = e.chan;
      end
    end
    unused_hi = '0;
    check_eq("res_valid", 32'(res_valid), 32'(exp_rv));
    check_eq("res_x", 32'(res_x), 32'(exp_rx));
    check_eq("res_y", 32'(res_y), 32'(exp_ry));
    check_eq("res_z", 32'(res_z), 32'(exp_rz));
    check_eq("res_chan", 32'(res_chan), 32'(exp_rc));
    check_eq("cordic_xi", {unused_hi[W-1:0], cordic_xi}, {unused_hi[W-1:0], exp_xi});
    check_eq("cordic_yi", 32'(cordic_yi), 32'(exp_yi));
    check_eq("cordic_zi", 32'(cordic_zi), 32'(exp_zi));
    check_eq("busy", 32'(busy), 32'(q.size() != 0));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ptr = N - 1;
    en_cnt = 0;
    rand_data = 1'b1;
    for (int k = 0; k < LAT; k++) cpipe[k] = '0;
    reset = 1'b1;
    stall = 1'b0;
    req_valid = '0;
    req_x = '0; req_y = '0; req_z = '0;

    repeat (3) cycle(4'b0000, 1'b0, 1'b1);

    // Single request from channel 2 with fixed operands
    rand_data = 1'b0;
    for (int i = 0; i < N; i++) begin
      dx[i] = '0; dy[i] = '0; dz[i] = '0;
    end
    dx[2] = 16'd1000;
    repeat (6) cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    rand_data = 1'b1;
    repeat (20) cycle(4'b0000, 1'b0, 1'b0);

    // All channels requesting
    repeat (16) cycle(4'b1111, 1'b0, 1'b0);
    repeat (16) cycle(4'b0000, 1'b0, 1'b0);

    // Channels 1 and 3 only, with an idle gap
    repeat (10) cycle(4'b1010, 1'b0, 1'b0);
    repeat (3) cycle(4'b0000, 1'b0, 1'b0);
    repeat (10) cycle(4'b1010, 1'b0, 1'b0);
    repeat (16) cycle(4'b0000, 1'b0, 1'b0);

    // Five-cycle stall with operations in flight
    repeat (8) cycle(4'b1111, 1'b0, 1'b0);
    repeat (5) cycle(4'b1111, 1'b1, 1'b0);
    repeat (25) cycle(4'b0000, 1'b0, 1'b0);

    // Reset with six operations in flight, then channel 0 wins first
    repeat (6) cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b1);
    repeat (20) cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    repeat (16) cycle(4'b0000, 1'b0, 1'b0);

    // Back-to-back channel 0
    repeat (30) cycle(4'b0001, 1'b0, 1'b0);
    repeat (16) cycle(4'b0000, 1'b0, 1'b0);

    // Random traffic with random stalls and occasional reset
    repeat (400) cycle(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));

    // Bounded drain
    repeat (20) cycle(4'b0000, 1'b0, 1'b0);
    check_eq("drain_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
